// File: rtl/axis_traffic_gen_pkg.sv
// axis_traffic_gen_pkg
//    Shared types and helpers for the AXIS traffic generator.
//    - state_t          : generator FSM states
//    - PRBS_* constants : PRBS-31 (x^31 + x^28 + 1) taps and start seed
//    - keep_mask()      : LSB-contiguous byte-enable mask for n kept bytes
//    - prbs_next_byte() : advances the PRBS register 8 bits, returns byte + new state
package axis_traffic_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [30:0] PRBS_SEED   = 31'h7FFF_FFFF;
   localparam int unsigned PRBS_TAP_HI = 30;   // x^31
   localparam int unsigned PRBS_TAP_LO = 27;   // x^28

   // Widest tkeep the keep_mask helper can describe.
   localparam int unsigned MAX_KEEP = 64;

   typedef struct packed {
      logic [7:0]  data;
      logic [30:0] state;
   } prbs_byte_t;

   function automatic logic [MAX_KEEP-1:0] keep_mask(input int unsigned n);
      logic [MAX_KEEP-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MAX_KEEP; i++) begin
         if (i < n) m[i] = 1'b1;
      end
      return m;
   endfunction

   // Fibonacci form; the first generated bit lands in data[7].
   function automatic prbs_byte_t prbs_next_byte(input logic [30:0] s);
      prbs_byte_t r;
      logic       fb;
      r.state = s;
      r.data  = '0;
      for (int i = 0; i < 8; i++) begin
         fb      = r.state[PRBS_TAP_HI] ^ r.state[PRBS_TAP_LO];
         r.state = {r.state[29:0], fb};
         r.data  = {r.data[6:0], fb};
      end
      return r;
   endfunction

endpackage

// File: rtl/axis_int.sv
// AXIS_int
//    AXI4-Stream bundle. DATA_BYTES byte lanes, USER_WIDTH tuser bits.
//    clk travels with the bundle and is driven by the master.
//    Master modport: drives clk/tvalid/tdata/tkeep/tlast/tuser, receives tready.
//    Slave modport : the mirror image.
interface AXIS_int #(
   parameter int DATA_BYTES = 4,
   parameter int USER_WIDTH = 1
);
   logic                      clk;
   logic                      tvalid;
   logic                      tready;
   logic [8*DATA_BYTES-1:0]   tdata;
   logic [DATA_BYTES-1:0]     tkeep;
   logic                      tlast;
   logic [USER_WIDTH-1:0]     tuser;

   modport Master (output clk, tvalid, tdata, tkeep, tlast, tuser, input tready);
   modport Slave  (input clk, tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/axis_traffic_gen_pattern.sv
// axis_traffic_gen_pattern
//    Per-beat data pattern for the traffic generator. Lanes below keep_cnt
//    carry the running byte sequence (or PRBS-31 bytes when built with
//    AXIS_TRAFFIC_GEN_PRBS_EN and prbs_sel=1); lanes at or above keep_cnt are 0.
//    The pattern state advances by keep_cnt bytes on each accepted beat.
// Ports
//    clk       in   clock
//    sreset    in   synchronous reset, active-high
//    init      in   restart the pattern (run start)
//    prbs_sel  in   select PRBS bytes (only meaningful with AXIS_TRAFFIC_GEN_PRBS_EN)
//    advance   in   current beat accepted
//    keep_cnt  in   kept bytes in the current beat
//    data      out  current beat tdata
module axis_traffic_gen_pattern
   import axis_traffic_gen_pkg::*;
#(
   parameter int DATA_BYTES = 4,
   parameter int KEEP_CNT_W = 3
) (
   input  logic                    clk,
   input  logic                    sreset,
   input  logic                    init,
   input  logic                    prbs_sel,
   input  logic                    advance,
   input  logic [KEEP_CNT_W-1:0]   keep_cnt,
   output logic [8*DATA_BYTES-1:0] data
);

   logic [7:0]              seq_q;
   logic [8*DATA_BYTES-1:0] data_inc;

   // Only the low byte of the stream sequence is ever visible on the bus.
   always_ff @(posedge clk) begin
      if (sreset || init) begin
         seq_q <= '0;
      end else if (advance) begin
         seq_q <= seq_q + 8'(keep_cnt);
      end
   end

   always_comb begin
      data_inc = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (i < int'(keep_cnt)) data_inc[8*i +: 8] = seq_q + 8'(i);
      end
   end

`ifdef AXIS_TRAFFIC_GEN_PRBS_EN
   logic [30:0]             lfsr_q;
   logic [30:0]             lfsr_next;
   logic [30:0]             lfsr_chain [DATA_BYTES+1];
   logic [8*DATA_BYTES-1:0] data_prbs;

   // Byte lanes are chained: lane i starts where lane i-1 left the register.
   always_comb begin
      prbs_byte_t pb;
      pb            = '0;
      data_prbs     = '0;
      lfsr_chain[0] = lfsr_q;
      lfsr_next     = lfsr_q;
      for (int i = 0; i < DATA_BYTES; i++) begin
         pb                = prbs_next_byte(lfsr_chain[i]);
         lfsr_chain[i+1]   = pb.state;
         if (i < int'(keep_cnt)) begin
            data_prbs[8*i +: 8] = pb.data;
            lfsr_next           = pb.state;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (sreset || init) begin
         lfsr_q <= PRBS_SEED;
      end else if (advance) begin
         lfsr_q <= lfsr_next;
      end
   end

   assign data = prbs_sel ? data_prbs : data_inc;
`else
   logic unused_prbs_sel;
   assign unused_prbs_sel = prbs_sel;
   assign data            = data_inc;
`endif

endmodule

// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen
//    Programmable AXI-Stream frame source: frames of cfg_frame_len bytes,
//    cfg_gap_cycles idle cycles between frames, cfg_num_frames per run
//    (0 = run until stopped), tuser error marking on every cfg_err_every-th
//    frame. Optional PRBS-31 data pattern: define AXIS_TRAFFIC_GEN_PRBS_EN.
//
//    state | meaning
//    IDLE  | no run; waits for start_stb
//    SEND  | tvalid high, presenting beats of the current frame
//    GAP   | tvalid low, counting inter-frame idle cycles
//
// Ports
//    clk            in   clock (also driven onto axis.clk)
//    sreset         in   synchronous reset, active-high
//    axis           AXIS_int.Master generated stream
//    start_stb      in   begin a run (IDLE only)
//    stop_stb       in   graceful stop; the current frame always completes
//    cfg_frame_len  in   bytes per frame, 0 rejected
//    cfg_gap_cycles in   idle cycles between frames
//    cfg_num_frames in   frames per run, 0 = unbounded
//    cfg_err_every  in   mark every Nth frame as errored, 0 = never
//    cfg_prbs_sel   in   PRBS data when built with AXIS_TRAFFIC_GEN_PRBS_EN
//    busy           out  not IDLE
//    done_stb       out  one-cycle pulse at run end
//    cfg_err_stb    out  one-cycle pulse when a start is rejected
//    frames_sent    out  frames accepted since start
//    bytes_sent     out  kept bytes accepted since start
module axis_traffic_gen
   import axis_traffic_gen_pkg::*;
#(
   parameter int                     COUNT_WIDTH     = 32,
   parameter int                     LEN_WIDTH       = 16,
   parameter int                     GAP_WIDTH       = 16,
   parameter int                     TUSER_WIDTH     = 1,
   parameter logic [TUSER_WIDTH-1:0] TUSER_ERR_VALUE = TUSER_WIDTH'(1)
) (
   input  logic                   clk,
   input  logic                   sreset,
   AXIS_int.Master                axis,
   input  logic                   start_stb,
   input  logic                   stop_stb,
   input  logic [LEN_WIDTH-1:0]   cfg_frame_len,
   input  logic [GAP_WIDTH-1:0]   cfg_gap_cycles,
   input  logic [COUNT_WIDTH-1:0] cfg_num_frames,
   input  logic [15:0]            cfg_err_every,
   input  logic                   cfg_prbs_sel,
   output logic                   busy,
   output logic                   done_stb,
   output logic                   cfg_err_stb,
   output logic [COUNT_WIDTH-1:0] frames_sent,
   output logic [COUNT_WIDTH-1:0] bytes_sent
);

   localparam int DATA_BYTES = $bits(axis.tkeep);
   localparam int KEEP_CNT_W = $clog2(DATA_BYTES + 1);

   if (TUSER_WIDTH != $bits(axis.tuser)) begin : g_tuser_width_chk
      $error("axis_traffic_gen: TUSER_WIDTH does not match the interface USER_WIDTH");
   end
   if (DATA_BYTES > MAX_KEEP) begin : g_keep_width_chk
      $error("axis_traffic_gen: interface wider than keep_mask supports");
   end

   state_t                  state_q, state_d;
   logic [LEN_WIDTH-1:0]    len_q, bytes_left_q;
   logic [GAP_WIDTH-1:0]    gap_q, gap_cnt_q;
   logic [COUNT_WIDTH-1:0]  frames_left_q, frames_sent_q, bytes_sent_q;
   logic [15:0]             err_every_q, err_cnt_q;
   logic                    unbounded_q, stop_q, prbs_sel_q, done_q, cfg_err_q;

   logic                    in_send, hs, last_beat, frame_end, run_end;
   logic                    start_req, start_ok, start_bad, err_frame;
   logic [KEEP_CNT_W-1:0]   keep_cnt;
   logic [MAX_KEEP-1:0]     keep_mask_all;
   logic [8*DATA_BYTES-1:0] pat_data;

   assign axis.clk = clk;

   // Beat bookkeeping: bytes_left_q counts down through the frame, so the
   // last beat is simply the one with at most DATA_BYTES bytes remaining.
   always_comb begin
      in_send       = (state_q == ST_SEND);
      hs            = in_send && axis.tready;
      last_beat     = (bytes_left_q <= LEN_WIDTH'(DATA_BYTES));
      keep_cnt      = last_beat ? KEEP_CNT_W'(bytes_left_q) : KEEP_CNT_W'(DATA_BYTES);
      keep_mask_all = keep_mask(32'(keep_cnt));
      frame_end     = hs && last_beat;
      // A stop arriving on the tlast beat itself still ends the run there.
      run_end       = frame_end &&
                      ((!unbounded_q && frames_left_q == COUNT_WIDTH'(1)) || stop_q || stop_stb);
      start_req     = (state_q == ST_IDLE) && start_stb && !stop_stb;
      start_ok      = start_req && (cfg_frame_len != '0);
      start_bad     = start_req && (cfg_frame_len == '0);
      // err_cnt_q counts down to the next errored frame.
      err_frame     = (err_every_q != '0) && (err_cnt_q == 16'd1);
   end

   if (DATA_BYTES < MAX_KEEP) begin : g_keep_hi
      logic unused_keep_hi;
      assign unused_keep_hi = ^keep_mask_all[MAX_KEEP-1:DATA_BYTES];
   end

   always_ff @(posedge clk) begin
      if (sreset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) state_d = ST_SEND;
         end
         ST_SEND: begin
            if (frame_end) begin
               if (run_end)             state_d = ST_IDLE;
               else if (gap_q != '0)    state_d = ST_GAP;
               else                     state_d = ST_SEND;
            end
         end
         ST_GAP: begin
            if (stop_stb)                          state_d = ST_IDLE;
            else if (gap_cnt_q == GAP_WIDTH'(1))   state_d = ST_SEND;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy        = (state_q != ST_IDLE);
      axis.tvalid = in_send;
      axis.tlast  = in_send && last_beat;
      axis.tkeep  = in_send ? keep_mask_all[DATA_BYTES-1:0] : '0;
      axis.tuser  = (in_send && last_beat && err_frame) ? TUSER_ERR_VALUE : '0;
      axis.tdata  = in_send ? pat_data : '0;
   end

   always_ff @(posedge clk) begin
      if (sreset) begin
         len_q         <= '0;
         bytes_left_q  <= '0;
         gap_q         <= '0;
         gap_cnt_q     <= '0;
         frames_left_q <= '0;
         frames_sent_q <= '0;
         bytes_sent_q  <= '0;
         err_every_q   <= '0;
         err_cnt_q     <= '0;
         unbounded_q   <= 1'b0;
         stop_q        <= 1'b0;
         prbs_sel_q    <= 1'b0;
         done_q        <= 1'b0;
         cfg_err_q     <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         cfg_err_q <= start_bad;

         if (start_ok) begin
            len_q         <= cfg_frame_len;
            bytes_left_q  <= cfg_frame_len;
            gap_q         <= cfg_gap_cycles;
            frames_left_q <= cfg_num_frames;
            unbounded_q   <= (cfg_num_frames == '0);
            err_every_q   <= cfg_err_every;
            err_cnt_q     <= cfg_err_every;
            prbs_sel_q    <= cfg_prbs_sel;
            stop_q        <= 1'b0;
            frames_sent_q <= '0;
            bytes_sent_q  <= '0;
         end

         if (in_send && stop_stb) stop_q <= 1'b1;

         if (hs) begin
            bytes_sent_q <= bytes_sent_q + COUNT_WIDTH'(keep_cnt);
            if (last_beat) begin
               frames_sent_q <= frames_sent_q + COUNT_WIDTH'(1);
               frames_left_q <= frames_left_q - COUNT_WIDTH'(1);
               bytes_left_q  <= len_q;
               gap_cnt_q     <= gap_q;
               err_cnt_q     <= (err_cnt_q == 16'd1) ? err_every_q : err_cnt_q - 16'd1;
               if (run_end) begin
                  done_q <= 1'b1;
                  stop_q <= 1'b0;
               end
            end else begin
               bytes_left_q <= bytes_left_q - LEN_WIDTH'(DATA_BYTES);
            end
         end

         if (state_q == ST_GAP) begin
            if (stop_stb) done_q <= 1'b1;
            else          gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
         end
      end
   end

   axis_traffic_gen_pattern #(
      .DATA_BYTES (DATA_BYTES),
      .KEEP_CNT_W (KEEP_CNT_W)
   ) u_pattern (
      .clk      (clk),
      .sreset   (sreset),
      .init     (start_ok),
      .prbs_sel (prbs_sel_q),
      .advance  (hs),
      .keep_cnt (keep_cnt),
      .data     (pat_data)
   );

   assign done_stb    = done_q;
   assign cfg_err_stb = cfg_err_q;
   assign frames_sent = frames_sent_q;
   assign bytes_sent  = bytes_sent_q;

endmodule
